// File: rtl/rf_codec_pkg.sv
// Shared definitions for the RF line-coding blocks: frame sequencer
// state encoding and the default preamble length and sync byte.
package rf_codec_pkg;

   localparam int         PREAMBLE_BITS_DEF = 16;
   localparam logic [7:0] SYNC_WORD_DEF     = 8'h2D;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREAMBLE = 3'd1,
      ST_SYNC     = 3'd2,
      ST_LEN      = 3'd3,
      ST_PAYLOAD  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/rf_tx_shifter.sv
// 8-bit load / shift-left register; the MSB is the bit currently on the line.
// Load has priority over shift.
module rf_tx_shifter (
   input  logic       clk2x,
   input  logic       rst_n,
   input  logic       load,
   input  logic       shift,
   input  logic [7:0] din,
   output logic       msb
);

   logic [7:0] sreg_reg;

   // Parallel load of a new field byte, otherwise move the next bit up to the MSB.
   always_ff @(posedge clk2x or negedge rst_n) begin
      if (!rst_n) begin
         sreg_reg <= '0;
      end else if (load) begin
         sreg_reg <= din;
      end else if (shift) begin
         sreg_reg <= {sreg_reg[6:0], 1'b0};
      end
   end

   assign msb = sreg_reg[7];

endmodule

// File: rtl/rf_frame_sequencer.sv
// Frame sequencer feeding a Manchester encoder: preamble, sync byte,
// length byte and payload bytes, each line bit held for two clk2x cycles.
module rf_frame_sequencer
   import rf_codec_pkg::*;
#(
   parameter int         PREAMBLE_BITS = PREAMBLE_BITS_DEF,
   parameter logic [7:0] SYNC_WORD     = SYNC_WORD_DEF
) (
   input  logic       clk2x,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] len,
   input  logic [7:0] data,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       enc_din,
   output logic       enc_enable,
   output logic       busy,
   output logic       done,
   output logic       underrun
);

   localparam logic [6:0] PRE_LAST  = 7'(PREAMBLE_BITS - 1);
   localparam logic [6:0] BYTE_LAST = 7'd7;

   seq_state_t state_reg, state_next;
   logic       phase_reg, phase_next;
   logic [6:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] len_reg, len_next;
   logic [7:0] rem_reg, rem_next;
   logic       done_reg, done_next;

   logic       sh_load;
   logic       sh_shift;
   logic [7:0] sh_din;
   logic       sh_msb;
   logic       byte_end;

   rf_tx_shifter u_shifter (
      .clk2x (clk2x),
      .rst_n (rst_n),
      .load  (sh_load),
      .shift (sh_shift),
      .din   (sh_din),
      .msb   (sh_msb)
   );

   // State register and frame counters.
   always_ff @(posedge clk2x or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         phase_reg   <= 1'b0;
         bit_cnt_reg <= '0;
         len_reg     <= '0;
         rem_reg     <= '0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         phase_reg   <= phase_next;
         bit_cnt_reg <= bit_cnt_next;
         len_reg     <= len_next;
         rem_reg     <= rem_next;
         done_reg    <= done_next;
      end
   end

   // Phase-1 cycle of the last bit of an 8-bit field.
   assign byte_end = phase_reg && (bit_cnt_reg == BYTE_LAST);

   // Next-state, field sequencing, payload handshake and abort.
   always_comb begin
      state_next   = state_reg;
      phase_next   = 1'b0;
      bit_cnt_next = bit_cnt_reg;
      len_next     = len_reg;
      rem_next     = rem_reg;
      done_next    = 1'b0;
      sh_load      = 1'b0;
      sh_shift     = 1'b0;
      sh_din       = data;
      data_ready   = 1'b0;
      underrun     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               len_next     = len;
               bit_cnt_next = '0;
               state_next   = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            phase_next = ~phase_reg;
            if (phase_reg) begin
               if (bit_cnt_reg == PRE_LAST) begin
                  state_next   = ST_SYNC;
                  bit_cnt_next = '0;
                  sh_load      = 1'b1;
                  sh_din       = SYNC_WORD;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 7'd1;
               end
            end
         end
         ST_SYNC: begin
            phase_next = ~phase_reg;
            if (byte_end) begin
               state_next   = ST_LEN;
               bit_cnt_next = '0;
               sh_load      = 1'b1;
               sh_din       = len_reg;
            end else if (phase_reg) begin
               sh_shift     = 1'b1;
               bit_cnt_next = bit_cnt_reg + 7'd1;
            end
         end
         ST_LEN, ST_PAYLOAD: begin
            phase_next = ~phase_reg;
            if (byte_end) begin
               bit_cnt_next = '0;
               // LEN ends the frame when len is zero; PAYLOAD when the last byte is out.
               if ((state_reg == ST_LEN) ? (len_reg == 8'd0) : (rem_reg == 8'd1)) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end else begin
                  data_ready = 1'b1;
                  if (data_valid) begin
                     sh_load    = 1'b1;
                     state_next = ST_PAYLOAD;
                     rem_next   = (state_reg == ST_LEN) ? len_reg : rem_reg - 8'd1;
                  end else begin
                     underrun   = 1'b1;
                     state_next = ST_IDLE;
                  end
               end
            end else if (phase_reg) begin
               sh_shift     = 1'b1;
               bit_cnt_next = bit_cnt_reg + 7'd1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign enc_enable = (state_reg != ST_IDLE);
   assign busy       = (state_reg != ST_IDLE);
   assign done       = done_reg;
   // Preamble alternates 1,0,... from the bit index; fields come from the shifter.
   assign enc_din    = (state_reg == ST_PREAMBLE) ? ~bit_cnt_reg[0] :
                       (enc_enable ? sh_msb : 1'b0);

endmodule

// File: doc/rf_frame_sequencer.md
RF_FRAME_SEQUENCER -- requirements
Module: rf_frame_sequencer

Interface
REQ-001 SHALL have parameter PREAMBLE_BITS, default 16, number of alternating preamble bits (even, 2..64).
REQ-002 SHALL have parameter SYNC_WORD, default 8'h2D, sync byte sent after the preamble.
REQ-003 SHALL have port clk2x  in  1  single clock, two cycles per line bit.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1  frame request, sampled in IDLE only.
REQ-006 SHALL have port len  in  8  payload byte count, captured with start.
REQ-007 SHALL have port data  in  8  payload byte.
REQ-008 SHALL have port data_valid  in  1  payload byte available.
REQ-009 SHALL have port data_ready  out  1  sequencer consumes a byte this cycle.
REQ-010 SHALL have port enc_din  out  1  bit to the Manchester encoder din.
REQ-011 SHALL have port enc_enable  out  1  encoder enable, high for the whole frame.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port done  out  1  one-cycle pulse on normal frame completion.
REQ-014 SHALL have port underrun  out  1  one-cycle pulse on payload abort.

Function
REQ-015 SHALL implement states IDLE, PREAMBLE, SYNC, LEN, PAYLOAD.
REQ-016 SHALL, in IDLE with start=1, capture len, clear the bit-phase flag and bit counter, and enter PREAMBLE on the next edge.
REQ-017 SHALL ignore start while busy=1.
REQ-018 SHALL hold each line bit on enc_din for exactly two clk2x cycles: phase 0, then phase 1; bits change only on entry to phase 0.
REQ-019 SHALL send PREAMBLE_BITS preamble bits 1,0,1,0,... (first bit 1), then SYNC_WORD MSB first, then the captured len MSB first, then len payload bytes MSB first.
REQ-020 SHALL skip PAYLOAD when len=0 and end the frame after the LEN byte.
REQ-021 SHALL assert data_ready combinationally, for exactly one cycle, in the phase-1 cycle of the last bit of LEN or of each payload byte except the last, with data loaded into the shift register when data_valid=1 in that cycle.
REQ-022 SHALL, if data_valid=0 while data_ready=1, abort: pulse underrun, drop enc_enable, and enter IDLE on the next edge; done is not pulsed.
REQ-023 SHALL hold enc_enable=1 from the first PREAMBLE cycle through the phase-1 cycle of the final bit: total 2*(PREAMBLE_BITS+16+8*len) cycles.
REQ-024 SHALL, on the edge after the final phase-1 cycle, enter IDLE with enc_enable=0, enc_din=0 and done=1 for one cycle; start is accepted again in that same cycle.
REQ-025 SHALL keep enc_din=0 whenever enc_enable=0.
REQ-026 SHALL use an 8-bit payload byte counter that does not wrap: len=255 sends 255 bytes.

Reset
REQ-027 SHALL, on rst_n low, asynchronously force IDLE, with enc_enable, enc_din, busy, done, underrun and data_ready all 0.
REQ-028 SHALL abandon a frame in progress on mid-frame reset with no done or underrun pulse; the first start after rst_n rises begins a fresh frame.

Structure
REQ-029 SHALL take its state encoding and the SYNC_WORD and PREAMBLE_BITS defaults from the shared package rf_codec_pkg.
REQ-030 SHALL use one sub-module, rf_tx_shifter (8-bit load/shift-left register with MSB output), shared by the SYNC, LEN and PAYLOAD fields.

Verification
REQ-031 SHALL cover: start, len=2, data 8'hA5 then 8'h3C always valid -> enc_enable high 96 cycles; bit stream 1010101010101010, 00101101, 00000010, 10100101, 00111100; done pulse at cycle 97.
REQ-032 SHALL cover: len=0 -> enc_enable high 64 cycles, data_ready never asserted, done pulse.
REQ-033 SHALL cover: len=3, data_valid dropped before the second byte -> underrun pulse at that byte boundary, enc_enable low next cycle, no done pulse.
REQ-034 SHALL cover: start re-asserted mid-frame -> ignored, and the frame length is unchanged.
REQ-035 SHALL cover: rst_n pulsed low during SYNC -> outputs 0 immediately, then a new start with len=1 gives a clean 80-cycle frame.
REQ-036 SHALL cover: start asserted in the done cycle -> the next frame's preamble begins on the next edge with no idle gap.
